// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU function codes and sequencer state encoding
package alu_pkg;
  localparam int DATA_W = 16;
  localparam int FUNC_W = 3;
  localparam int NREG   = 4;
  localparam int REG_AW = 2;
  localparam logic [FUNC_W-1:0] FUNC_ADD = 3'd0;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 3'd1;
  localparam logic [FUNC_W-1:0] FUNC_AND = 3'd2;
  localparam logic [FUNC_W-1:0] FUNC_OR  = 3'd3;
  localparam logic [FUNC_W-1:0] FUNC_NOT = 3'd4;
  localparam logic [FUNC_W-1:0] FUNC_NEG = 3'd5;
  localparam logic [FUNC_W-1:0] FUNC_SHL = 3'd6;
  localparam logic [FUNC_W-1:0] FUNC_SRA = 3'd7;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: two combinational read ports, one write port where writeback beats direct load
module alu_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] ra0,
  input  logic [REG_AW-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  logic [DATA_W-1:0] rf [NREG];
  assign rd0 = rf[ra0];
  assign rd1 = rf[ra1];
  // per-entry write: clear on reset, writeback first, then direct load
  always_ff @(posedge clk)
    for (int i = 0; i < NREG; i++)
      if (!reset_n) rf[i] <= '0;
      else if (wb_en && wb_addr == REG_AW'(i)) rf[i] <= wb_data;
      else if (ld_en && ld_addr == REG_AW'(i)) rf[i] <= ld_data;
endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issues register-indexed ops to an external ALU and writes results back
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int NREG   = alu_pkg::NREG,
  parameter int REG_AW = alu_pkg::REG_AW,
  parameter int FUNC_W = alu_pkg::FUNC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FUNC_W-1:0] req_func,
  input  logic [REG_AW-1:0] req_rs,
  input  logic [REG_AW-1:0] req_rt,
  input  logic [REG_AW-1:0] req_rd,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_ovf,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf,
  output logic [REG_AW-1:0] rsp_rd,
  output logic              ovf_sticky,
  input  logic              ovf_clear
);
  state_t state, nxt;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic accept, wb, ovf_m;
  assign req_ready = state == IDLE || (state == RESP && rsp_ready);
  assign rsp_valid = state == RESP;
  assign accept    = req_valid && req_ready;
  assign wb        = state == EXEC;
  assign ovf_m     = alu_ovf && alu_func <= FUNC_SUB;
  alu_regfile #(.DATA_W(DATA_W), .NREG(NREG), .REG_AW(REG_AW)) u_rf (
    .clk(clk), .reset_n(reset_n),
    .ra0(req_rs), .ra1(req_rt), .rd0(rs_val), .rd1(rt_val),
    .wb_en(wb), .wb_addr(rd_q), .wb_data(alu_c),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );
  // next state: IDLE waits for accept, EXEC lasts one cycle, RESP waits for rsp_ready
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? EXEC : IDLE;
      EXEC:    nxt = RESP;
      default: nxt = rsp_ready ? (req_valid ? EXEC : IDLE) : RESP;
    endcase
  end
  // state, operand latches at accept, result capture at end of EXEC, sticky overflow
  always_ff @(posedge clk)
    if (!reset_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
      rd_q       <= '0;
      rsp_data   <= '0;
      rsp_ovf    <= 1'b0;
      rsp_rd     <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      state      <= nxt;
      ovf_sticky <= (wb && ovf_m) || (ovf_sticky && !ovf_clear);
      if (accept) begin
        alu_a    <= rs_val;
        alu_b    <= rt_val;
        alu_func <= req_func;
        rd_q     <= req_rd;
      end
      if (wb) begin
        rsp_data <= alu_c;
        rsp_ovf  <= ovf_m;
        rsp_rd   <= rd_q;
      end
    end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed checks of the issue sequencer around a behavioural ALU
module tb_alu_issue_seq;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [2:0] req_func = '0;
  logic [1:0] req_rs = '0, req_rt = '0, req_rd = '0;
  logic ld_en = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [2:0] alu_func;
  logic alu_ovf;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic rsp_ovf;
  logic [1:0] rsp_rd;
  logic ovf_sticky, ovf_clear = 1'b0;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  alu_issue_seq dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_c(alu_c), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .rsp_rd(rsp_rd), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  // behavioural ALU; its flag reads 1 for logic/shift ops so masking is exercised
  always_comb begin
    alu_c = '0;
    alu_ovf = 1'b1;
    case (alu_func)
      3'd0: begin alu_c = alu_a + alu_b; alu_ovf = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]); end
      3'd1: begin alu_c = alu_a - alu_b; alu_ovf = (alu_a[15] != alu_b[15]) && (alu_c[15] != alu_a[15]); end
      3'd2: alu_c = alu_a & alu_b;
      3'd3: alu_c = alu_a | alu_b;
      3'd4: alu_c = ~alu_a;
      3'd5: alu_c = -alu_a;
      3'd6: alu_c = alu_a << 1;
      default: alu_c = 16'($signed(alu_a) >>> 1);
    endcase
  end

  task automatic ld(input logic [1:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [1:0] s, input logic [1:0] t, input logic [1:0] d,
                        input logic xe, input logic [1:0] xa, input logic [15:0] xd,
                        output logic [15:0] data, output logic ovf, output logic v, output logic [1:0] r);
    req_func = f; req_rs = s; req_rt = t; req_rd = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ld_en = xe; ld_addr = xa; ld_data = xd;
    @(posedge clk); #1;
    ld_en = 1'b0;
    data = rsp_data; ovf = rsp_ovf; v = rsp_valid; r = rsp_rd;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [15:0] data);
    logic o, v;
    logic [1:0] r;
    run_op(3'd3, a, a, a, 1'b0, 2'd0, 16'h0, data, o, v, r);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else pass++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else pass++;
    total++; if ({alu_a, alu_b, alu_func} !== 35'h0) $display("FAIL reset_alu_out: got %h want 0", {alu_a, alu_b, alu_func}); else pass++;
    total++; if ({rsp_data, rsp_ovf, rsp_rd, ovf_sticky} !== 20'h0) $display("FAIL reset_rsp: got %h want 0", {rsp_data, rsp_ovf, rsp_rd, ovf_sticky}); else pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_add_ovf;
    logic [15:0] d, r2;
    logic o, v;
    logic [1:0] r;
    ld(2'd0, 16'h7FFF);
    ld(2'd1, 16'h0001);
    run_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 16'h0, d, o, v, r);
    total++; if (v !== 1'b1) $display("FAIL t1_valid: got %b want 1", v); else pass++;
    total++; if (d !== 16'h8000) $display("FAIL t1_data: got %h want 8000", d); else pass++;
    total++; if (o !== 1'b1) $display("FAIL t1_ovf: got %b want 1", o); else pass++;
    total++; if (r !== 2'd2) $display("FAIL t1_rd: got %0d want 2", r); else pass++;
    total++; if (ovf_sticky !== 1'b1) $display("FAIL t1_sticky: got %b want 1", ovf_sticky); else pass++;
    read_reg(2'd2, r2);
    total++; if (r2 !== 16'h8000) $display("FAIL t1_r2: got %h want 8000", r2); else pass++;
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    total++; if (ovf_sticky !== 1'b0) $display("FAIL t1_clear: got %b want 0", ovf_sticky); else pass++;
  endtask

  task automatic test_sub_mask;
    logic [15:0] d;
    logic o, v;
    logic [1:0] r;
    ld(2'd0, 16'h8000);
    ld(2'd1, 16'h0001);
    run_op(3'd1, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 16'h0, d, o, v, r);
    total++; if (d !== 16'h7FFF) $display("FAIL t2_sub_data: got %h want 7fff", d); else pass++;
    total++; if (o !== 1'b1) $display("FAIL t2_sub_ovf: got %b want 1", o); else pass++;
    ld(2'd3, 16'h8002);
    run_op(3'd7, 2'd3, 2'd3, 2'd1, 1'b0, 2'd0, 16'h0, d, o, v, r);
    total++; if (d !== 16'hC001) $display("FAIL t2_sra_data: got %h want c001", d); else pass++;
    total++; if (o !== 1'b0) $display("FAIL t2_sra_ovf_mask: got %b want 0", o); else pass++;
  endtask

  task automatic test_back_to_back;
    ld(2'd0, 16'h0003);
    ld(2'd1, 16'h0004);
    req_func = 3'd0; req_rs = 2'd0; req_rt = 2'd1; req_rd = 2'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_rs = 2'd1; req_rt = 2'd1; req_rd = 2'd2;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0007 || rsp_rd !== 2'd3)
        $display("FAIL t3_hold%0d: got v=%b d=%h rd=%0d want v=1 d=0007 rd=3", i, rsp_valid, rsp_data, rsp_rd); else pass++;
      total++; if (req_ready !== 1'b0) $display("FAIL t3_req_ready%0d: got %b want 0", i, req_ready); else pass++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 1'b1) $display("FAIL t3_req_ready_up: got %b want 1", req_ready); else pass++;
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0) $display("FAIL t3_exec_valid: got %b want 0", rsp_valid); else pass++;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0008 || rsp_rd !== 2'd2)
      $display("FAIL t3_second: got v=%b d=%h rd=%0d want v=1 d=0008 rd=2", rsp_valid, rsp_data, rsp_rd); else pass++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_collision;
    logic [15:0] d;
    logic o, v;
    logic [1:0] r;
    ld(2'd0, 16'hF0F0);
    ld(2'd1, 16'h0FF0);
    run_op(3'd2, 2'd0, 2'd1, 2'd2, 1'b1, 2'd2, 16'hAAAA, d, o, v, r);
    read_reg(2'd2, d);
    total++; if (d !== 16'h00F0) $display("FAIL t4_wb_wins: got %h want 00f0", d); else pass++;
    ld(2'd2, 16'h1234);
    run_op(3'd2, 2'd0, 2'd1, 2'd2, 1'b1, 2'd3, 16'hAAAA, d, o, v, r);
    read_reg(2'd3, d);
    total++; if (d !== 16'hAAAA) $display("FAIL t4_r3_ld: got %h want aaaa", d); else pass++;
    read_reg(2'd2, d);
    total++; if (d !== 16'h00F0) $display("FAIL t4_r2_wb: got %h want 00f0", d); else pass++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    ld(2'd0, 16'h7FFF);
    ld(2'd1, 16'h0001);
    req_func = 3'd0; req_rs = 2'd0; req_rt = 2'd1; req_rd = 2'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL t5_idle: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready); else pass++;
    total++; if (ovf_sticky !== 1'b0 || rsp_data !== 16'h0) $display("FAIL t5_cleared: got sticky=%b d=%h want 0 0", ovf_sticky, rsp_data); else pass++;
    read_reg(2'd2, d);
    total++; if (d !== 16'h0) $display("FAIL t5_rd_untouched: got %h want 0000", d); else pass++;
  endtask

  task automatic test_ovf_clear;
    ld(2'd0, 16'h7FFF);
    ld(2'd1, 16'h0001);
    req_func = 3'd0; req_rs = 2'd0; req_rt = 2'd1; req_rd = 2'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    total++; if (ovf_sticky !== 1'b1) $display("FAIL t6_set_wins: got %b want 1", ovf_sticky); else pass++;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0; rsp_ready = 1'b0;
    total++; if (ovf_sticky !== 1'b0) $display("FAIL t6_clear: got %b want 0", ovf_sticky); else pass++;
  endtask

  initial begin
    test_reset;
    test_add_ovf;
    test_sub_mask;
    test_back_to_back;
    test_collision;
    test_reset_mid;
    test_ovf_clear;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
